// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for if_id_queue.
// The queue uses the slave modport; the fetch/decode side uses master.
interface if_id_queue_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_ready;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of DEPTH {inst, pc} entries between fetch and decode.
// Optional same-cycle bypass when empty is compiled in with IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  if_id_queue_if.slave             q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   cnt;

  logic empty, full, stored_vld, byp, push, pop, wr;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  always_comb begin
    byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    byp = empty & q.in_valid & ~flush;
`endif
    stored_vld  = ~empty & ~flush;
    q.in_ready  = ~full & ~flush;
    q.out_valid = stored_vld | byp;
    q.out_inst  = '0;
    q.out_pc    = '0;
    if (stored_vld) begin
      q.out_inst = mem[head].inst;
      q.out_pc   = mem[head].pc;
    end else if (byp) begin
      q.out_inst = q.in_inst;
      q.out_pc   = q.in_pc;
    end
    push = q.in_valid & q.in_ready;
    pop  = stored_vld & q.out_ready;
    // A bypassed entry that decode takes immediately never lands in storage.
    wr   = push & ~(byp & q.out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (wr)  tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end

  // Storage is not reset; entries are only observable through count.
  always_ff @(posedge clk) begin
    if (rst && wr) mem[tail] <= '{inst: q.in_inst, pc: q.in_pc};
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=4) with a queue-based scoreboard of stored entries.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] count;
  if_id_queue_if bus ();

  if_id_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .flush(flush), .count(count), .q(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [95:0] sb [$];

  task automatic drive(input bit iv, input logic [31:0] inst, input logic [63:0] pc,
                       input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
  endtask

  // Update the reference model from the inputs just driven, then clock.
  task automatic advance();
    bit rdy, vld, byp;
    rdy = (sb.size() != DEPTH) && !flush;
    vld = (sb.size() != 0) && !flush;
    byp = BYP && (sb.size() == 0) && bus.in_valid && !flush;
    if (!rst || flush) sb.delete();
    else begin
      if (vld && bus.out_ready) void'(sb.pop_front());
      if (bus.in_valid && rdy && !(byp && bus.out_ready)) sb.push_back({bus.in_inst, bus.in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 32'hDEAD_BEEF, 64'h1234, 1, 1);
    advance();
    advance();
    rst = 1'b1;
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_pc !== 64'h0 || bus.out_inst !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h/%h want 0/0", bus.out_inst, bus.out_pc); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single_push();
    drive(1, 32'h0000_0013, 64'h8000_0000, 0, 0);
    vectors++; if (bus.out_valid !== BYP) begin miscompares++; $display("FAIL single_same_cycle_valid got %b want %b", bus.out_valid, BYP); end
    advance();
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_pc !== 64'h8000_0000) begin miscompares++; $display("FAIL single_pc got %h want 80000000", bus.out_pc); end
    vectors++; if (bus.out_inst !== 32'h0000_0013) begin miscompares++; $display("FAIL single_inst got %h want 00000013", bus.out_inst); end
    vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
    drive(0, 32'h0, 64'h0, 1, 0);
    advance();
    drive(0, 32'h0, 64'h0, 1, 0);
    vectors++; if (count !== CW'(0) || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got count %0d valid %b want 0 0", count, bus.out_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hA000_0000 + 32'(i), 64'h9000_0000 + 64'(i) * 64'h10, 0, 0);
      vectors++; if (bus.in_ready !== (i < 4)) begin miscompares++; $display("FAIL full_in_ready[%0d] got %b want %b", i, bus.in_ready, i < 4); end
      advance();
    end
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (count !== CW'(4)) begin miscompares++; $display("FAIL full_count got %0d want 4", count); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready_after got %b want 0", bus.in_ready); end
  endtask

  task automatic test_full_pop();
    drive(1, 32'hBBBB_BBBB, 64'hB000_0000, 1, 0);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fullpop_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_pc !== 64'h9000_0000) begin miscompares++; $display("FAIL fullpop_head got %h want 90000000", bus.out_pc); end
    advance();
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (count !== CW'(3)) begin miscompares++; $display("FAIL fullpop_count got %0d want 3", count); end
    vectors++; if (bus.out_pc !== 64'h9000_0010 || bus.out_inst !== 32'hA000_0001) begin miscompares++; $display("FAIL fullpop_next got %h/%h want a0000001/90000010", bus.out_inst, bus.out_pc); end
    vectors++; if (sb.size() != 3 || bus.out_pc !== sb[0][63:0]) begin miscompares++; $display("FAIL fullpop_model got %h want %h", bus.out_pc, sb[0][63:0]); end
  endtask

  task automatic test_flush();
    drive(1, 32'hCCCC_CCCC, 64'hC000_0000, 1, 1);
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_handshake got valid %b ready %b want 0 0", bus.out_valid, bus.in_ready); end
    vectors++; if (bus.out_pc !== 64'h0) begin miscompares++; $display("FAIL flush_out_pc got %h want 0", bus.out_pc); end
    advance();
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL flush_count got %0d want 0", count); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_after got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_stream();
    int k = 0, npop = 0, cyc = 0;
    bit ordy, exp_v;
    while ((k < 10 || sb.size() != 0) && cyc < 200) begin
      ordy = (cyc % 2 == 1);
      drive(k < 10, 32'h0000_0013 + 32'(k), 64'h8000_0000 + 64'(k) * 64'd4, ordy, 0);
      exp_v = (sb.size() != 0) || (BYP && k < 10);
      vectors++; if (bus.out_valid !== exp_v) begin miscompares++; $display("FAIL stream_valid cyc %0d got %b want %b", cyc, bus.out_valid, exp_v); end
      if (exp_v && ordy) begin
        vectors++; if (bus.out_pc !== 64'h8000_0000 + 64'(npop) * 64'd4) begin miscompares++; $display("FAIL stream_order got %h want %h", bus.out_pc, 64'h8000_0000 + 64'(npop) * 64'd4); end
        npop++;
      end
      if (k < 10 && sb.size() != DEPTH) k++;
      advance();
      cyc++;
    end
    vectors++; if (npop != 10 || cyc >= 200) begin miscompares++; $display("FAIL stream_total got %0d pops in %0d cycles want 10", npop, cyc); end
  endtask

  task automatic test_bypass();
    drive(1, 32'h0000_0093, 64'h8000_0010, 1, 0);
    vectors++; if (bus.out_valid !== BYP) begin miscompares++; $display("FAIL bypass_valid got %b want %b", bus.out_valid, BYP); end
    if (BYP) begin
      vectors++; if (bus.out_pc !== 64'h8000_0010) begin miscompares++; $display("FAIL bypass_pc got %h want 80000010", bus.out_pc); end
    end
    advance();
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (count !== CW'(BYP ? 0 : 1)) begin miscompares++; $display("FAIL bypass_count got %0d want %0d", count, BYP ? 0 : 1); end
    drive(0, 32'h0, 64'h0, 1, 0);
    advance();
    drive(0, 32'h0, 64'h0, 0, 0);
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL bypass_drain got %0d want 0", count); end
  endtask

  initial begin
    drive(0, 32'h0, 64'h0, 0, 0);
    test_reset();
    test_single_push();
    test_full();
    test_full_pop();
    test_flush();
    test_stream();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered fetch entries; legal values are 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset), sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1 bit: the fetch stage presents an instruction this cycle.
REQ-005 SHALL have port in_inst, input, 32 bits: the fetched instruction word.
REQ-006 SHALL have port in_pc, input, 64 bits (addr_t): the PC of in_inst.
REQ-007 SHALL have port in_ready, output, 1 bit: the queue accepts a push this cycle; fetch uses it as its enable.
REQ-008 SHALL have port out_valid, output, 1 bit: the head entry is valid toward decode.
REQ-009 SHALL have port out_inst, output, 32 bits: the head instruction.
REQ-010 SHALL have port out_pc, output, 64 bits: the head PC.
REQ-011 SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-012 SHALL have port flush, input, 1 bit: redirect or branch mispredict; discard all entries.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of stored entries.

Function
REQ-014 SHALL implement a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL perform a push when in_valid & in_ready: store {in_inst, in_pc} at tail, then tail+1 and count+1.
REQ-016 SHALL perform a pop when out_valid & out_ready: head+1 and count-1.
REQ-017 SHALL hold count unchanged on a simultaneous push and pop and SHALL update both pointers.
REQ-018 SHALL drive in_ready = (count != DEPTH) & !flush; a full queue does not accept a push, even when a pop occurs in the same cycle.
REQ-019 SHALL drive out_valid = (count != 0) & !flush, with out_inst and out_pc taken from entry[head].
REQ-020 SHALL drive out_inst and out_pc to 0 whenever out_valid = 0.
REQ-021 SHALL give flush priority over everything else: in the flush cycle no push or pop occurs, and on the next edge head = tail = count = 0.
REQ-022 SHALL ignore in_valid while in_ready = 0; the producer holds its data until accepted.
REQ-023 SHALL make a pushed entry visible on out_* no earlier than the cycle after the push, unless the bypass in REQ-028 applies.
REQ-024 SHALL keep count within 0..DEPTH at all times; an out_ready on an empty queue is a no-op.

Reset
REQ-025 SHALL, when rst = 0 at a rising edge, set head = 0, tail = 0 and count = 0, so that out_valid = 0, out_inst = 0, out_pc = 0 and in_ready = 1 from the next cycle.
REQ-026 SHALL let reset override flush, push and pop in the same cycle, and SHALL discard in-flight entries.
REQ-027 SHALL leave storage array contents unreset; they are unobservable while count = 0.

Configuration
REQ-028 SHALL compile in a bypass path when IF_ID_QUEUE_BYPASS_EN is defined: when count = 0, in_valid = 1 and flush = 0, out_valid = 1 and out_* = in_* combinationally; if out_ready = 1 the entry is consumed without being stored (count stays 0), otherwise it is stored normally.
REQ-029 SHALL, when IF_ID_QUEUE_BYPASS_EN is undefined, have no combinational path from in_* to out_*, with a minimum fetch-to-decode latency of 1 cycle.

Verification
REQ-030 SHALL pass: reset, then push 0x00000013 at pc 0x80000000 with out_ready = 0 -> next cycle out_valid = 1, out_pc = 0x80000000, count = 1.
REQ-031 SHALL pass: DEPTH = 4, push 5 consecutive entries with out_ready = 0 -> in_ready = 0 after the 4th push, the 5th is not accepted, count = 4.
REQ-032 SHALL pass: full queue with in_valid = 1 and out_ready = 1 for one cycle -> the pop occurs, no push, count = 3, and the head advances to the 2nd entry.
REQ-033 SHALL pass: 3 entries, then flush = 1 with in_valid = 1 and out_ready = 1 -> out_valid = 0 and in_ready = 0 that cycle, count = 0 next cycle, and the pushed entry is lost.
REQ-034 SHALL pass: stream 10 pushes at pc 0x80000000+4k with out_ready toggling every cycle -> pops in pc order with wrap-around, nothing lost or duplicated.
REQ-035 SHALL pass: with the macro, an empty queue, and in_valid = out_ready = 1 at pc 0x80000010 -> out_pc = 0x80000010 in the same cycle and count stays 0; without the macro -> out_valid = 0 that cycle.
